sw_led_debounce: RTL and testbench

SW_LED_DEBOUNCE -- requirements
Module: sw_led_debounce

---
 rtl/sw_led_debounce.sv | 143 ++++++++++++++
 tb/tb_sw_led_debounce.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_led_debounce.sv
// -----------------------------------------------------------------------------
// sw_led_debounce
//
// Purpose:
//   Synchronizes and debounces WIDTH independent switch inputs and drives one
//   LED per channel. Each channel passes its switch through a two-flop
//   synchronizer. A new level is accepted only after DEBOUNCE_CYCLES
//   consecutive synchronized samples that differ from the current debounced
//   level. Every accepted level change raises a one-cycle event pulse.
//
//   A set switch level that is then held reaches the debounced level
//   DEBOUNCE_CYCLES+1 edges after the first edge that samples it.
//
// Configuration:
//   SW_LED_TOGGLE_EN  - when defined, builds the toggle display. With mode=1,
//                       each rising debounced edge flips a per-channel toggle
//                       bit and the LED shows that bit. When undefined, mode
//                       is ignored and the LED always shows the debounced level.
//
// Parameters:
//   WIDTH            - number of switch/LED channels (>=1)
//   DEBOUNCE_CYCLES  - consecutive differing samples needed to accept (>=1)
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      asynchronous active-high reset
//   sw    in   WIDTH  raw asynchronous switch levels
//   mode  in   1      0 = direct display, 1 = toggle display
//   led   out  WIDTH  registered LED drive
//   evt   out  WIDTH  registered one-cycle pulse on accepted level change
// -----------------------------------------------------------------------------
module sw_led_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             mode,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] evt
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] led_nxt;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];

    // NOTE: every flop below uses non-blocking assignments so all registers
    // sample the pre-edge values, which is what makes s1 -> s2 a real
    // two-stage synchronizer rather than a single wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Per-channel debounce. The counter tracks how many consecutive samples
    // have disagreed with the debounced level; it accepts on the last one and
    // clears, so it can never wrap.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_nxt[i] = stable[i];
            cnt_nxt[i]    = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: the counter array is reset explicitly, element by element; it is
    // a bank of flops, not a RAM, and a partial count must not survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef SW_LED_TOGGLE_EN
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] tog_nxt;
    logic [WIDTH-1:0] rise;

    // Toggle bits only advance while toggle display is selected, and only on
    // a 0->1 debounced transition; they hold their value across mode changes.
    always_comb begin
        rise    = stable_nxt & ~stable;
        tog_nxt = mode ? (tog ^ rise) : tog;
        led_nxt = mode ? tog_nxt : stable_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tog <= '0;
        end else begin
            tog <= tog_nxt;
        end
    end
`else
    // Display is fixed to the debounced level; mode is accepted but unused.
    logic unused_mode;
    assign unused_mode = mode;

    always_comb begin
        led_nxt = stable_nxt;
    end
`endif

    // led and evt are computed from the next debounced value so they change
    // on the same edge as stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            led    <= '0;
            evt    <= '0;
        end else begin
            stable <= stable_nxt;
            led    <= led_nxt;
            evt    <= stable_nxt ^ stable;
        end
    end

endmodule

// File: tb/tb_sw_led_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_led_debounce
//
// Self-checking bench for sw_led_debounce (WIDTH=16, DEBOUNCE_CYCLES=4).
// A behavioural reference produces the expected led/evt for each clock edge
// when inputs are applied; the expectation is queued and compared after the
// edge. Directed latency checks count edges until an LED changes.
// Toggle-mode scenarios are compiled only when SW_LED_TOGGLE_EN is defined.
// -----------------------------------------------------------------------------
module tb_sw_led_debounce;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [W-1:0] sw;
    logic [W-1:0] led;
    logic [W-1:0] evt;

    sw_led_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .mode(mode),
        .led (led),
        .evt (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] led;
        logic [W-1:0] evt;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: two-stage delay of sw, accepted level, run length of
    // disagreeing samples since the last acceptance, toggle bits, outputs.
    logic [W-1:0] m_d1;
    logic [W-1:0] m_d2;
    logic [W-1:0] m_lvl;
    logic [W-1:0] m_tog;
    logic [W-1:0] m_led;
    logic [W-1:0] m_evt;
    int           m_run [W];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_d1  = '0;
        m_d2  = '0;
        m_lvl = '0;
        m_tog = '0;
        m_led = '0;
        m_evt = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endfunction

    // Expected outcome of one rising edge with the current inputs.
    function automatic void model_edge();
        logic [W-1:0] nl;
        nl = m_lvl;
        for (int i = 0; i < W; i++) begin
            if (m_d2[i] === m_lvl[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= D) begin
                    nl[i]    = m_d2[i];
                    m_run[i] = 0;
                end
            end
        end
`ifdef SW_LED_TOGGLE_EN
        for (int i = 0; i < W; i++) begin
            if (mode && !m_lvl[i] && nl[i]) m_tog[i] = ~m_tog[i];
        end
        m_led = mode ? m_tog : nl;
`else
        m_led = nl;
`endif
        m_evt = nl ^ m_lvl;
        m_lvl = nl;
        m_d2  = m_d1;
        m_d1  = sw;
    endfunction

    // One clock: queue the expectation, let the edge happen, compare after it.
    task automatic step();
        exp_t e;
        if (rst) model_reset();
        else     model_edge();
        sb.push_back({m_led, m_evt});
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        check("led", led, e.led);
        check("evt", evt, e.evt);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Count edges until (led & mask) becomes nonzero, bounded.
    task automatic edges_to_led(input logic [W-1:0] mask, output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            n = k;
            if ((led & mask) != '0) break;
        end
        if ((led & mask) == '0) n = 99;
    endtask

    initial begin
        int n;

        // Asynchronous reset with all switches high: outputs zero before any edge.
        rst  = 1'b1;
        sw   = '1;
        mode = 1'b0;
        model_reset();
        #2;
        check("rst_async_led", led, 16'h0000);
        check("rst_async_evt", evt, 16'h0000);
        steps(10);
        check("rst_hold_led", led, 16'h0000);

        // Release with switches low; first edges are ordinary.
        sw  = '0;
        rst = 1'b0;
        steps(4);

        // Single channel press: LED on the sixth edge, one-cycle event.
        sw[0] = 1'b1;
        edges_to_led(16'h0001, n);
        check("lat_sw0", 16'(n), 16'd6);
        check("sw0_led", led, 16'h0001);
        check("sw0_evt", evt, 16'h0001);
        step();
        check("sw0_evt_drop", evt, 16'h0000);
        sw[0] = 1'b0;
        steps(8);

        // Bounce of three samples on sw[3] must be ignored.
        sw[3] = 1'b1;
        steps(3);
        sw[3] = 1'b0;
        steps(10);
        check("bounce_led", led, 16'h0000);

        // Multi-channel simultaneous change.
        sw = 16'hA5A5;
        edges_to_led(16'hFFFF, n);
        check("lat_a5a5", 16'(n), 16'd6);
        check("a5a5_led", led, 16'hA5A5);
        check("a5a5_evt", evt, 16'hA5A5);
        steps(3);
        sw = '0;
        steps(8);
        check("a5a5_clear", led, 16'h0000);

        // Reset mid-count discards partial count; acceptance restarts.
        sw[1] = 1'b1;
        steps(3);
        rst = 1'b1;
        step();
        check("midrst_led", led, 16'h0000);
        rst = 1'b0;
        edges_to_led(16'h0002, n);
        check("lat_after_rst", 16'(n), 16'd6);
        sw[1] = 1'b0;
        steps(8);

        // Asynchronous reset with LEDs lit, taking effect between edges.
        sw = 16'h00F0;
        steps(8);
        #3;
        rst = 1'b1;
        #1;
        check("async_mid_led", led, 16'h0000);
        check("async_mid_evt", evt, 16'h0000);
        sw = '0;
        steps(2);
        rst = 1'b0;
        steps(2);

`ifdef SW_LED_TOGGLE_EN
        // Toggle display: two press/release cycles on sw[5].
        mode  = 1'b1;
        sw[5] = 1'b1;
        steps(10);
        check("tog_press1", led, 16'h0020);
        sw[5] = 1'b0;
        steps(10);
        check("tog_rel1", led, 16'h0020);
        sw[5] = 1'b1;
        steps(10);
        check("tog_press2", led, 16'h0000);
        sw[5] = 1'b0;
        steps(10);
        check("tog_rel2", led, 16'h0000);
        // Toggle bit survives a detour through direct mode.
        sw[5] = 1'b1;
        steps(10);
        mode = 1'b0;
        sw[5] = 1'b0;
        steps(10);
        check("tog_direct", led, 16'h0000);
        mode = 1'b1;
        step();
        check("tog_kept", led, 16'h0020);
        steps(2);
`else
        // Mode has no effect in the default build.
        mode  = 1'b1;
        sw[5] = 1'b1;
        steps(10);
        check("mode_ignored_on", led, 16'h0020);
        sw[5] = 1'b0;
        steps(10);
        check("mode_ignored_off", led, 16'h0000);
`endif

        // Random bouncing traffic against the reference.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) sw = sw ^ 16'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
